// File: rtl/if_id_fetch_stage.sv
// Fetch stage: owns the PC, issues word requests to instruction memory and
// holds the IF/ID pipeline register (instruction, PC, PC+4, valid).
module if_id_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [1:0]  fsm_state_o
);

  // Handshake: a request is outstanding whenever imem_req_o=1; it completes in
  // the cycle imem_ready_i=1, when imem_rdata_i carries the word at imem_addr_o.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_bits;

  assign redirect_tgt         = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          instr_d = 32'h0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (imem_ready_i && !stall_i) begin
          instr_d  = imem_rdata_i;
          pc_out_d = pc_q;
          pc4_d    = pc_q + 32'd4;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
        end else if (imem_ready_i && stall_i) begin
          // Park the returned word so the stall never drops it.
          skid_instr_d = imem_rdata_i;
          skid_pc_d    = pc_q;
          pc_d         = pc_q + 32'd4;
          state_d      = S_HOLD;
        end else if (!stall_i) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          instr_d = 32'h0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          instr_d  = skid_instr_q;
          pc_out_d = skid_pc_q;
          pc4_d    = skid_pc_q + 32'd4;
          valid_d  = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= PC_RESET;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      instr_q      <= 32'h0;
      pc_out_q     <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign pc_plus4_o  = pc4_q;
  assign valid_o     = valid_q;
  assign fsm_state_o = state_q;

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
Fetch stage and IF/ID pipeline register feeding the ID/EX register.
- Owns the program counter and issues word requests to instruction memory with a req/ready handshake.
- Holds the fetched instruction, its PC and PC+4 in the IF/ID register.
- Honours a stall from the hazard unit and a taken-branch redirect from EX, inserting all-zero bubbles (opcode 000000, R-type NOP) when needed.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; returns all state to reset values
stall_i  input  1  hazard-unit stall: IF/ID must hold its contents
redirect_i  input  1  taken branch/jump resolved in EX
redirect_pc_i  input  32  target PC for redirect_i; bits [1:0] ignored (treated as 00)
imem_req_o  output  1  instruction-memory request valid
imem_addr_o  output  32  request word address, equals internal PC
imem_ready_i  input  1  memory returns data this cycle for the current request
imem_rdata_i  input  32  instruction word, valid when imem_ready_i=1
instr_o  output  32  IF/ID instruction to decode
pc_o  output  32  IF/ID PC of instr_o
pc_plus4_o  output  32  IF/ID pc_o+4
valid_o  output  1  1 = instr_o is a real instruction, 0 = bubble

Behaviour:
Reset (async, immediate):
- pc_q=PC_RESET; state=S_BOOT; skid buffer cleared.
- imem_req_o=0, instr_o=0, pc_o=0, pc_plus4_o=0, valid_o=0.

Memory interface (combinational from state):
- imem_req_o=1 only in S_FETCH; imem_addr_o=pc_q always.
- imem_ready_i and imem_rdata_i are ignored outside S_FETCH.

FSM:
- S_BOOT: one cycle after reset deassertion, then S_FETCH. IF/ID holds its reset values.
- S_FETCH:
  - ready=1, stall=0: IF/ID <= {rdata, pc_q, pc_q+4, valid=1}; pc_q <= pc_q+4; stay. This gives one instruction per cycle with single-cycle memory.
  - ready=1, stall=1: IF/ID holds; skid <= {rdata, pc_q}; pc_q <= pc_q+4; go to S_HOLD.
  - ready=0, stall=0: IF/ID <= bubble (instr=0, valid=0, pc_o/pc_plus4_o hold); stay.
  - ready=0, stall=1: IF/ID holds; stay.
- S_HOLD:
  - imem_req_o=0.
  - stall=1: IF/ID holds.
  - stall=0: IF/ID <= {skid instr, skid pc, skid pc+4, valid=1}; go to S_FETCH.

Redirect (redirect_i=1) has highest priority in every state except S_BOOT, and overrides stall:
- pc_q <= {redirect_pc_i[31:2],2'b00}.
- IF/ID <= bubble (instr=0, valid=0).
- Skid buffer discarded; any imem data returned that cycle discarded.
- Next state S_FETCH. First request to the target is issued the following cycle.
- In S_BOOT, redirect_i is ignored.

Arithmetic and boundary conditions:
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- pc_plus4_o is always the registered pc_o+4, never recomputed combinationally.
- Stall never drops a fetched instruction: every ready=1 response outside a redirect cycle reaches IF/ID exactly once, in program order.
- Reset asserted mid-handshake or in S_HOLD: outstanding data is lost; fetch restarts at PC_RESET.

Test Plan:
- Reset, imem_ready_i tied 1, memory returns addr|0xA000_0000: after S_BOOT, instr_o sequence A0000000, A0000004, A0000008 with valid_o=1 on consecutive cycles; pc_plus4_o = pc_o+4.
- Stall 2 cycles while ready=1 at PC 0x8: instr_o stays at PC 0x4's word; imem_req_o=0 during S_HOLD; on release, instr_o=A0000008 then A000000C. No duplicate, no gap.
- ready=0 for 3 cycles at PC 0x10: valid_o=0, instr_o=0 for those cycles, imem_addr_o stays 0x10; then A0000010 delivered.
- redirect_i with redirect_pc_i=0x0000_0103 while stalled in S_HOLD: next cycle valid_o=0, imem_addr_o=0x100; skid word never appears; following instr_o=A0000100.
- PC_RESET=32'hFFFF_FFF8: fetched pc_o sequence FFFFFFF8, FFFFFFFC, 00000000.
- Assert reset mid-stall with valid_o=1: outputs immediately 0 (no clock edge needed); fetch resumes at PC_RESET.
